// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI master sequencer.
package hpi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StChipRst,
      StWaitW,
      StSetup,
      StStrobe,
      StHold
   } hpi_state_e;

   localparam logic [1:0] HPI_REG_DATA    = 2'd0;
   localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_REG_ADDR    = 2'd2;
   localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_master_if.sv
// Request/stream handshake plus EZ-OTG HPI pin bundle; master = sequencer side.
interface hpi_master_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned LEN_W  = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic [DATA_W-1:0] wdata;
   logic              wdata_valid;
   logic              wdata_ready;
   logic [DATA_W-1:0] rdata;
   logic              rdata_valid;
   logic              done;
   logic              rst_req;
   logic [ADDR_W-1:0] otg_hpi_address;
   logic              otg_hpi_cs_n;
   logic              otg_hpi_r_n;
   logic              otg_hpi_w_n;
   logic              otg_hpi_reset_n;
   logic [DATA_W-1:0] otg_hpi_data_out;
   logic              otg_hpi_data_oe;
   logic [DATA_W-1:0] otg_hpi_data_in;

   modport master (
      input  req_valid, req_write, req_addr, req_len, wdata, wdata_valid, rst_req,
             otg_hpi_data_in,
      output req_ready, wdata_ready, rdata, rdata_valid, done, otg_hpi_address,
             otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_reset_n, otg_hpi_data_out,
             otg_hpi_data_oe
   );

   modport slave (
      output req_valid, req_write, req_addr, req_len, wdata, wdata_valid, rst_req,
             otg_hpi_data_in,
      input  req_ready, wdata_ready, rdata, rdata_valid, done, otg_hpi_address,
             otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_reset_n, otg_hpi_data_out,
             otg_hpi_data_oe
   );
endinterface

// File: rtl/hpi_phase_timer.sv
// Per-phase down-counter: load with a phase length N, last is high on the N-th cycle.
module hpi_phase_timer #(
   parameter int unsigned CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val - CNT_W'(1);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == '0);
endmodule

// File: rtl/hpi_master.sv
// HPI bus-cycle sequencer. Define HPI_INPUT_REG_EN to register otg_hpi_data_in
// before capture (capture and rdata_valid slip one HOLD cycle later).
module hpi_master
   import hpi_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ADDR_W     = 2,
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned STROBE_CYC = 4,
   parameter int unsigned HOLD_CYC   = 2,
   parameter int unsigned MAX_BURST  = 16,
   parameter int unsigned RESET_CYC  = 64
) (
   input  logic         clk_clk,
   input  logic         reset_reset_n,
   hpi_master_if.master bus
);
   localparam int unsigned LEN_W   = $clog2(MAX_BURST + 1);
   localparam int unsigned MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int unsigned MAX_B   = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
   localparam int unsigned MAX_CYC = (MAX_B > RESET_CYC) ? MAX_B : RESET_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   hpi_state_e        state_q;
   logic              wr_q;
   logic [LEN_W-1:0]  words_q;
   logic              cs_n_q, r_n_q, w_n_q, rst_n_q, oe_q, rvalid_q, done_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] dout_q, rdata_q;
   logic              tmr_load, tmr_last, last_word;
   logic [CNT_W-1:0]  tmr_val, tmr_cnt;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      if (len == '0) return LEN_W'(1);
      if (len > LEN_W'(MAX_BURST)) return LEN_W'(MAX_BURST);
      return len;
   endfunction

   assign last_word = (words_q == LEN_W'(1));

`ifdef HPI_INPUT_REG_EN
   logic [DATA_W-1:0] din_q;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) din_q <= '0;
      else                din_q <= bus.otg_hpi_data_in;
   end

   if (HOLD_CYC < 2) begin : g_hold_chk
      $error("HOLD_CYC must be >= 2 when HPI_INPUT_REG_EN is defined");
   end
`endif

   // Timer is reloaded on every transition into a timed phase.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = CNT_W'(SETUP_CYC);
      unique case (state_q)
         StIdle: begin
            if (bus.rst_req) begin
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(RESET_CYC);
            end else if (bus.req_valid && !bus.req_write) begin
               tmr_load = 1'b1;
            end
         end
         StWaitW:  tmr_load = bus.wdata_valid;
         StSetup: begin
            tmr_load = tmr_last;
            tmr_val  = CNT_W'(STROBE_CYC);
         end
         StStrobe: begin
            tmr_load = tmr_last;
            tmr_val  = CNT_W'(HOLD_CYC);
         end
         StHold:   tmr_load = tmr_last && !last_word && !wr_q;
         default:  tmr_load = 1'b0;
      endcase
   end

   hpi_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .cnt      (tmr_cnt),
      .last     (tmr_last)
   );

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q  <= StIdle;
         wr_q     <= 1'b0;
         words_q  <= '0;
         cs_n_q   <= 1'b1;
         r_n_q    <= 1'b1;
         w_n_q    <= 1'b1;
         rst_n_q  <= 1'b1;
         oe_q     <= 1'b0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         dout_q   <= '0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.rst_req) begin
                  rst_n_q <= 1'b0;
                  state_q <= StChipRst;
               end else if (bus.req_valid) begin
                  wr_q    <= bus.req_write;
                  addr_q  <= bus.req_addr;
                  words_q <= clamp_len(bus.req_len);
                  if (bus.req_write) begin
                     state_q <= StWaitW;
                  end else begin
                     cs_n_q  <= 1'b0;
                     state_q <= StSetup;
                  end
               end
            end
            StChipRst: begin
               if (tmr_last) begin
                  rst_n_q <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            StWaitW: begin
               if (bus.wdata_valid) begin
                  dout_q  <= bus.wdata;
                  cs_n_q  <= 1'b0;
                  oe_q    <= 1'b1;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               // Follow-on read words enter with cs_n high for their first SETUP cycle.
               cs_n_q <= 1'b0;
               if (tmr_last) begin
                  r_n_q   <= wr_q;
                  w_n_q   <= !wr_q;
                  state_q <= StStrobe;
               end
            end
            StStrobe: begin
               if (tmr_last) begin
                  r_n_q   <= 1'b1;
                  w_n_q   <= 1'b1;
                  state_q <= StHold;
`ifndef HPI_INPUT_REG_EN
                  if (!wr_q) begin
                     rdata_q  <= bus.otg_hpi_data_in;
                     rvalid_q <= 1'b1;
                  end
`endif
                  if (HOLD_CYC == 1 && last_word) done_q <= 1'b1;
               end
            end
            StHold: begin
`ifdef HPI_INPUT_REG_EN
               if (!wr_q && tmr_cnt == CNT_W'(HOLD_CYC - 1)) begin
                  rdata_q  <= din_q;
                  rvalid_q <= 1'b1;
               end
`endif
               if (last_word && tmr_cnt == CNT_W'(1)) done_q <= 1'b1;
               if (tmr_last) begin
                  cs_n_q  <= 1'b1;
                  oe_q    <= 1'b0;
                  words_q <= words_q - LEN_W'(1);
                  if (last_word)  state_q <= StIdle;
                  else if (wr_q)  state_q <= StWaitW;
                  else            state_q <= StSetup;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.req_ready        = reset_reset_n && (state_q == StIdle) && !bus.rst_req;
   assign bus.wdata_ready      = reset_reset_n && (state_q == StWaitW) && bus.wdata_valid;
   assign bus.rdata            = rdata_q;
   assign bus.rdata_valid      = rvalid_q;
   assign bus.done             = done_q;
   assign bus.otg_hpi_address  = addr_q;
   assign bus.otg_hpi_cs_n     = cs_n_q;
   assign bus.otg_hpi_r_n      = r_n_q;
   assign bus.otg_hpi_w_n      = w_n_q;
   assign bus.otg_hpi_reset_n  = rst_n_q;
   assign bus.otg_hpi_data_out = dout_q;
   assign bus.otg_hpi_data_oe  = oe_q;
endmodule

// File: tb/tb_hpi_master.sv
// Bench for hpi_master: per-burst expected waveforms built from the bus-cycle timing rules.
module tb_hpi_master;
   import hpi_pkg::*;

   localparam int unsigned DW   = 16;
   localparam int unsigned AW   = 2;
   localparam int unsigned SC   = 2;
   localparam int unsigned STC  = 4;
   localparam int unsigned HC   = 2;
   localparam int unsigned MAXB = 16;
   localparam int unsigned RC   = 64;
   localparam int unsigned LW   = $clog2(MAXB + 1);
   localparam int unsigned PER  = SC + STC + HC;
   localparam int          NC   = 600;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hpi_master_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();

   hpi_master #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .SETUP_CYC  (SC),
      .STROBE_CYC (STC),
      .HOLD_CYC   (HC),
      .MAX_BURST  (MAXB),
      .RESET_CYC  (RC)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .bus           (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Per-cycle stimulus and expectations, indexed by cycle after the accept edge.
   bit          wv     [NC];
   logic [15:0] wd     [NC];
   logic [15:0] din    [NC];
   bit          e_cs   [NC];
   bit          e_rd   [NC];
   bit          e_wr   [NC];
   bit          e_rv   [NC];
   bit          e_dn   [NC];
   bit          e_wrdy [NC];
   logic [15:0] e_rdat [NC];
   logic [15:0] e_dout [NC];

   task automatic issue(input bit wr, input logic [1:0] addr, input int len);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_len   = LW'(len);
      @(negedge clk);
      check("req_ready_idle", 32'(bus.req_ready), 1);
      @(posedge clk); #1;
   endtask

   // gap_mode 0: wdata_valid always high, 1: random gaps, 2: 5-cycle gap before word 3.
   task automatic run_burst(input bit wr, input logic [1:0] addr, input int len,
                            input int gap_mode, input int fix_din, input bit seq);
      int n, t, base, c, last, hs;
      n = (len == 0) ? 1 : ((len > MAXB) ? MAXB : len);
      for (int i = 0; i < NC; i++) begin
         wv[i]     = (gap_mode == 1) ? ((i % 8 == 0) || ($urandom_range(0, 3) != 0)) : 1'b1;
         wd[i]     = 16'($urandom);
         din[i]    = (fix_din >= 0) ? 16'(fix_din) : 16'($urandom);
         e_cs[i]   = 1'b0;
         e_rd[i]   = 1'b0;
         e_wr[i]   = 1'b0;
         e_rv[i]   = 1'b0;
         e_dn[i]   = 1'b0;
         e_wrdy[i] = 1'b0;
         e_rdat[i] = '0;
         e_dout[i] = '0;
      end
      t = 1;
      c = 0;
      for (int k = 0; k < n; k++) begin
         if (wr) begin
            if (gap_mode == 2 && k == 2) for (int i = t; i < t + 5; i++) wv[i] = 1'b0;
            c = t;
            while (!wv[c]) c++;
            if (seq) wd[c] = 16'(k + 1);
            e_wrdy[c] = 1'b1;
            base = c + 1;
         end else begin
            base = t;
         end
         for (int i = base; i < base + PER; i++) begin
            e_cs[i]   = wr || (k == 0) || (i > base);
            e_dout[i] = wd[c];
         end
         for (int i = base + SC; i < base + SC + STC; i++) begin
            if (wr) e_wr[i] = 1'b1;
            else    e_rd[i] = 1'b1;
         end
         if (!wr) begin
            e_rv[base + SC + STC]   = 1'b1;
            e_rdat[base + SC + STC] = din[base + SC + STC - 1];
         end
         t = base + PER;
      end
      e_dn[t - 1] = 1'b1;
      last = t;
      hs = 0;
      for (int cy = 1; cy <= last; cy++) begin
         bus.req_valid       = 1'b0;
         bus.wdata_valid     = wv[cy];
         bus.wdata           = wd[cy];
         bus.otg_hpi_data_in = din[cy];
         @(negedge clk);
         check("cs_n", 32'(bus.otg_hpi_cs_n), 32'(!e_cs[cy]));
         check("r_n", 32'(bus.otg_hpi_r_n), 32'(!e_rd[cy]));
         check("w_n", 32'(bus.otg_hpi_w_n), 32'(!e_wr[cy]));
         check("reset_n", 32'(bus.otg_hpi_reset_n), 1);
         check("data_oe", 32'(bus.otg_hpi_data_oe), 32'(wr && e_cs[cy]));
         check("rdata_valid", 32'(bus.rdata_valid), 32'(e_rv[cy]));
         check("done", 32'(bus.done), 32'(e_dn[cy]));
         check("wdata_ready", 32'(bus.wdata_ready), 32'(e_wrdy[cy]));
         check("req_ready", 32'(bus.req_ready), 32'(cy == last));
         if (e_cs[cy]) check("address", 32'(bus.otg_hpi_address), 32'(addr));
         if (wr && e_cs[cy]) check("data_out", 32'(bus.otg_hpi_data_out), 32'(e_dout[cy]));
         if (e_rv[cy]) check("rdata", 32'(bus.rdata), 32'(e_rdat[cy]));
         if (bus.wdata_ready && bus.wdata_valid) hs++;
         @(posedge clk); #1;
      end
      bus.wdata_valid = 1'b0;
      if (wr) check("wdata_handshakes", 32'(hs), 32'(n));
   endtask

   task automatic burst(input bit wr, input logic [1:0] addr, input int len,
                        input int gap_mode, input int fix_din, input bit seq);
      issue(wr, addr, len);
      run_burst(wr, addr, len, gap_mode, fix_din, seq);
   endtask

   initial begin
      bus.req_valid       = 1'b0;
      bus.req_write       = 1'b0;
      bus.req_addr        = '0;
      bus.req_len         = '0;
      bus.wdata           = '0;
      bus.wdata_valid     = 1'b0;
      bus.rst_req         = 1'b0;
      bus.otg_hpi_data_in = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cs_n", 32'(bus.otg_hpi_cs_n), 1);
      check("rst_r_n", 32'(bus.otg_hpi_r_n), 1);
      check("rst_w_n", 32'(bus.otg_hpi_w_n), 1);
      check("rst_reset_n", 32'(bus.otg_hpi_reset_n), 1);
      check("rst_address", 32'(bus.otg_hpi_address), 0);
      check("rst_data_out", 32'(bus.otg_hpi_data_out), 0);
      check("rst_data_oe", 32'(bus.otg_hpi_data_oe), 0);
      check("rst_rdata", 32'(bus.rdata), 0);
      check("rst_rdata_valid", 32'(bus.rdata_valid), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_wdata_ready", 32'(bus.wdata_ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("req_ready_after_release", 32'(bus.req_ready), 1);
      @(posedge clk); #1;

      // Directed bursts
      burst(1'b0, HPI_REG_STATUS, 1, 0, 16'hA5C3, 1'b0);
      burst(1'b1, HPI_REG_DATA, 4, 0, -1, 1'b1);
      burst(1'b1, HPI_REG_DATA, 5, 2, -1, 1'b1);
      burst(1'b0, HPI_REG_MAILBOX, 3, 0, -1, 1'b0);

      // Chip reset has priority over a simultaneous request
      bus.rst_req   = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = HPI_REG_STATUS;
      bus.req_len   = LW'(1);
      @(negedge clk);
      check("req_ready_rst_prio", 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      bus.rst_req = 1'b0;
      for (int c = 1; c <= int'(RC); c++) begin
         @(negedge clk);
         check("chiprst_reset_n", 32'(bus.otg_hpi_reset_n), 0);
         check("chiprst_req_ready", 32'(bus.req_ready), 0);
         check("chiprst_done", 32'(bus.done), 0);
         check("chiprst_cs_n", 32'(bus.otg_hpi_cs_n), 1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("chiprst_end_done", 32'(bus.done), 1);
      check("chiprst_end_reset_n", 32'(bus.otg_hpi_reset_n), 1);
      check("chiprst_end_req_ready", 32'(bus.req_ready), 1);
      @(posedge clk); #1;
      run_burst(1'b0, HPI_REG_STATUS, 1, 0, -1, 1'b0);

      // Reset during STROBE of a read burst
      issue(1'b0, HPI_REG_ADDR, 3);
      for (int c = 1; c <= 3; c++) begin
         bus.req_valid = 1'b0;
         bus.otg_hpi_data_in = 16'($urandom);
         @(negedge clk);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_r_n_before", 32'(bus.otg_hpi_r_n), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_cs_n", 32'(bus.otg_hpi_cs_n), 1);
      check("midrst_r_n", 32'(bus.otg_hpi_r_n), 1);
      check("midrst_w_n", 32'(bus.otg_hpi_w_n), 1);
      check("midrst_rdata_valid", 32'(bus.rdata_valid), 0);
      check("midrst_done", 32'(bus.done), 0);
      check("midrst_req_ready", 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("postrst_req_ready", 32'(bus.req_ready), 1);
         check("postrst_rdata_valid", 32'(bus.rdata_valid), 0);
         check("postrst_done", 32'(bus.done), 0);
         check("postrst_cs_n", 32'(bus.otg_hpi_cs_n), 1);
         @(posedge clk); #1;
      end

      // Length boundaries
      burst(1'b0, HPI_REG_DATA, 0, 0, -1, 1'b0);
      burst(1'b1, HPI_REG_DATA, 0, 0, -1, 1'b0);
      burst(1'b1, HPI_REG_DATA, int'(MAXB) + 5, 0, -1, 1'b1);
      burst(1'b0, HPI_REG_DATA, int'(MAXB) + 5, 0, -1, 1'b0);
      burst(1'b0, HPI_REG_MAILBOX, int'(MAXB), 0, -1, 1'b0);

      // Randomized bursts
      for (int i = 0; i < 25; i++) begin
         burst(1'($urandom), 2'($urandom), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 1)), -1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/hpi_master.md
# hpi_master

Hardware sequencer that generates EZ-OTG HPI bus cycles (address, cs, read/write strobes, chip reset, 16-bit data) from a simple request/stream handshake. It replaces software bit-banging of the HPI through individual PIO exports. It sits between an on-chip master (CPU-side bridge or keyboard/USB engine) and the top-level HPI pins. It supports parametrised bus timing, data width and multi-word bursts to a fixed HPI register.

## Interface
Parameters:
- DATA_W, 16, HPI data width
- ADDR_W, 2, HPI register address width
- SETUP_CYC, 2, cycles address/cs/data held before strobe (min 1)
- STROBE_CYC, 4, cycles r_n/w_n held low (min 1)
- HOLD_CYC, 2, cycles address/cs/data held after strobe (min 1)
- MAX_BURST, 16, maximum words per request
- RESET_CYC, 64, cycles otg_hpi_reset_n held low on chip-reset request

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  HPI register (0 data, 1 mailbox, 2 address, 3 status)
- req_len  in  $clog2(MAX_BURST+1)  words in burst; 0 treated as 1; values above MAX_BURST clamp to MAX_BURST
- wdata  in  DATA_W  write word
- wdata_valid  in  1  write word available
- wdata_ready  out  1  write word consumed this cycle
- rdata  out  DATA_W  read word
- rdata_valid  out  1  one-cycle pulse per read word, no backpressure
- done  out  1  one-cycle pulse after last word's HOLD, or at end of chip reset
- rst_req  in  1  request HPI chip reset
- otg_hpi_address  out  ADDR_W
- otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_reset_n  out  1 each, active low
- otg_hpi_data_out  out  DATA_W
- otg_hpi_data_oe  out  1  top-level tristate enable
- otg_hpi_data_in  in  DATA_W

## Operation
- States: IDLE, CHIPRST, WAIT_W, SETUP, STROBE, HOLD.
- IDLE: req_ready = 1 only here and only when rst_req = 0. rst_req has priority over req_valid when both are asserted.
- rst_req in IDLE -> CHIPRST. otg_hpi_reset_n is low for exactly RESET_CYC cycles, then done pulses and the block returns to IDLE.
- Accept: latch write flag, address, and clamped length into the word counter.
  - Write -> WAIT_W. Read -> SETUP.
- WAIT_W: cs_n stays high. When wdata_valid = 1: wdata_ready pulses, the word is latched into otg_hpi_data_out, go to SETUP.
- SETUP (SETUP_CYC cycles): cs_n low, address driven, data_oe = write flag.
- STROBE (STROBE_CYC cycles): r_n or w_n low.
- Read: otg_hpi_data_in is captured on the last STROBE cycle. rdata_valid pulses on the first HOLD cycle.
- HOLD (HOLD_CYC cycles): strobe high, cs_n/address/data unchanged. After HOLD, decrement the counter:
  - nonzero: write -> WAIT_W, read -> SETUP (cs_n goes high for one cycle between words).
  - zero: done pulses, go to IDLE.
- Address is held constant across a burst; the HPI data port auto-increments internally.
- Reset values: cs_n = r_n = w_n = reset_n = 1; address = 0; data_out = 0; data_oe = 0; rdata = 0; all pulses and req_ready = 0 during reset. req_ready = 1 on the first cycle after reset release.
- Reset mid-transaction: all strobes deassert on the reset edge and the burst is abandoned. done does not pulse.

## Timing
- Accept at edge T: for reads, SETUP starts at T+1. For writes, WAIT_W is at T+1 and SETUP starts at T+2 at the earliest.
- Word period: read = SETUP_CYC + STROBE_CYC + HOLD_CYC. Write = that period + 1 (WAIT_W), assuming wdata_valid is held high.
- Read latency from accept to first rdata_valid: SETUP_CYC + STROBE_CYC + 1 cycles.
- A new request can be accepted on the cycle after done pulses.
- r_n and w_n are never low simultaneously. A strobe is never low while cs_n is high.

## Configuration
- HPI_INPUT_REG_EN defined:
  - otg_hpi_data_in passes through one register stage before capture.
  - Capture moves to the first HOLD cycle; rdata_valid moves to the second HOLD cycle.
  - HOLD_CYC must be ≥ 2; a parameter check fails elaboration otherwise.
  - Read latency grows by 1.
- Not defined: direct capture on the last STROBE cycle as described above.

## Structure
- hpi_pkg: state enum; register address constants HPI_REG_DATA, HPI_REG_MAILBOX, HPI_REG_ADDR, HPI_REG_STATUS.
- Sub-module hpi_phase_timer: down-counter loaded per phase with SETUP_CYC/STROBE_CYC/HOLD_CYC/RESET_CYC, asserting `last` on the final cycle. Shared by all timed states.

## Test plan
- Defaults, single read of addr 3, data_in = 16'hA5C3 -> cs_n low for 8 cycles, r_n low for cycles 3–6, rdata = 16'hA5C3 with rdata_valid 7 cycles after accept, done one cycle later.
- Write burst len 4 to addr 0, words 1,2,3,4, wdata_valid always high -> four w_n pulses of 4 cycles each, data_out matches per word, wdata_ready pulses exactly 4 times, word period 9 cycles.
- Write burst with wdata_valid dropped for 5 cycles before word 3 -> cs_n high throughout the gap, no strobe, burst completes with correct data.
- rst_req and req_valid asserted in the same IDLE cycle -> reset_n low for 64 cycles, req_ready low, then done, then request accepted.
- reset_reset_n asserted during STROBE of a read burst -> next cycle all HPI strobes high, no rdata_valid/done, req_ready high after release.
- req_len = 0 -> exactly one word. req_len = MAX_BURST + 5 (if representable) -> MAX_BURST words.
